icache_hit_read_pipe: RTL and testbench
=======================================

ICACHE_HIT_READ_PIPE -- requirements
Module: icache_hit_read_pipe

Interface
REQ-001 SHALL have parameter INDEX_W, 6, set index width.
REQ-002 SHALL have parameter WAY_N, 8, associativity; WAY_W = clog2(WAY_N).
REQ-003 SHALL have parameter OFFSET_W, 6, line byte-offset width.
REQ-004 SHALL have parameter BANK_W, 128, data-array read width in bits.
REQ-005 SHALL have parameter FETCH_W, 64, response width in bits; BANK_W/FETCH_W is a power of two ≥1.
REQ-006 SHALL have ports: clock in 1, system clock; reset in 1, synchronous active-high reset; both single-clock, fixed.
REQ-007 SHALL have req_valid in 1, req_ready out 1, req_index in INDEX_W, req_way in WAY_W, req_offset in OFFSET_W; ctrl request channel.
REQ-008 SHALL have resp_valid out 1, resp_ready in 1, resp_rdata out FETCH_W; ctrl response channel.
REQ-009 SHALL have da_valid out 1, da_index out INDEX_W, da_way out WAY_W, da_bank out BSEL_W, da_rdata in BANK_W; data-array port, BSEL_W = OFFSET_W − clog2(BANK_W/8).
REQ-010 SHALL have plru_valid out 1, plru_index out INDEX_W, plru_way out WAY_W; PLRU touch.
REQ-011 SHALL have flush in 1 only when ICACHE_HIT_READ_FLUSH_EN is defined.

Function
REQ-012 SHALL accept a request on req_valid & req_ready (accept).
REQ-013 SHALL drive da_valid = plru_valid = accept; da_index/plru_index = req_index, da_way/plru_way = req_way, da_bank = req_offset[OFFSET_W-1 : clog2(BANK_W/8)].
REQ-014 SHALL assume da_rdata valid exactly one cycle after da_valid, held for that cycle only.
REQ-015 SHALL register word select wsel = req_offset[clog2(BANK_W/8)-1 : clog2(FETCH_W/8)] on accept; resp_rdata = FETCH_W slice wsel of selected source.
REQ-016 SHALL implement FSM {EMPTY, LIVE, HELD}: LIVE = response sourced from da_rdata, HELD = response sourced from hold register.
REQ-017 SHALL transition EMPTY→LIVE on accept; else stay.
REQ-018 SHALL in LIVE: resp_ready&accept→LIVE; resp_ready&!accept→EMPTY; !resp_ready→HELD, capturing selected word.
REQ-019 SHALL in HELD: resp_ready&accept→LIVE; resp_ready&!accept→EMPTY; !resp_ready→HELD, hold unchanged.
REQ-020 SHALL drive resp_valid = (state≠EMPTY); req_ready = (state==EMPTY) | resp_ready (combinational from resp_ready permitted).
REQ-021 SHALL give one-cycle accept-to-resp_valid latency and sustain one response per cycle with resp_ready high.
REQ-022 SHALL keep resp_rdata stable while resp_valid & !resp_ready.

Reset
REQ-023 SHALL on reset force state EMPTY, hold register and wsel 0; resp_valid, da_valid, plru_valid 0 while reset high; req_ready 0 while reset high.
REQ-024 SHALL discard any in-flight response when reset asserts mid-operation; no response emitted after release.

Configuration
REQ-025 SHALL, with ICACHE_HIT_READ_FLUSH_EN defined, on flush force state EMPTY next cycle, force req_ready, da_valid, plru_valid 0 that cycle; flush dominates resp_ready and accept.
REQ-026 SHALL, without ICACHE_HIT_READ_FLUSH_EN, omit flush port and logic; behaviour otherwise identical.

Structure
REQ-027 SHALL place FSM state enum and clog2-derived width constants in shared package icache_pkg.
REQ-028 SHALL reuse existing dff_en for wsel and hold registers; no other sub-module.

Verification
REQ-029 SHALL test default params: req offset 0x08 at cycle 0, resp_ready=1 -> da_bank=0, resp_valid cycle 1, resp_rdata=da_rdata[127:64].
REQ-030 SHALL test back-to-back: 4 accepts cycles 0-3, resp_ready=1 -> 4 responses cycles 1-4, req_ready constantly 1.
REQ-031 SHALL test stall: resp_ready=0 cycles 1-3 -> state HELD, resp_rdata unchanged after da_rdata changes, req_ready=0; ready cycle 4 -> one response consumed.
REQ-032 SHALL test FETCH_W=32, BANK_W=128: offset 0x3C -> da_bank=3, resp_rdata=da_rdata[127:96].
REQ-033 SHALL test reset asserted in HELD -> resp_valid 0 next cycle, no response after release.
REQ-034 SHALL test (FLUSH_EN) flush with req_valid=1 in LIVE -> no da_valid/plru_valid that cycle, resp_valid 0 next cycle.

Source files
------------

// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM state encoding and clog2-derived width helpers for the icache hit-read pipe
package icache_pkg;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_LIVE  = 2'd1;
  localparam logic [1:0] ST_HELD  = 2'd2;
  function automatic int min1_clog2(input int v);
    return v > 1 ? $clog2(v) : 1;
  endfunction
  function automatic int byte_lsb(input int bits);
    return $clog2(bits / 8);
  endfunction
endpackage

// File: rtl/dff_en.sv
// dff_en: enabled register with synchronous active-high reset to zero
module dff_en #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  // load on enable, clear on reset
  always_ff @(posedge clk_i)
    if (rst_i) q_o <= '0;
    else if (en_i) q_o <= d_i;
endmodule

// File: rtl/icache_hit_read_pipe.sv
// icache_hit_read_pipe: hit-read pipe, data-array read plus word select with skid hold; ICACHE_HIT_READ_FLUSH_EN adds a flush input
module icache_hit_read_pipe
  import icache_pkg::*;
#(
  parameter int INDEX_W   = 6,
  parameter int WAY_N     = 8,
  parameter int OFFSET_W  = 6,
  parameter int BANK_W    = 128,
  parameter int FETCH_W   = 64,
  localparam int WAY_W    = min1_clog2(WAY_N),
  localparam int BANK_LSB = byte_lsb(BANK_W),
  localparam int WORD_LSB = byte_lsb(FETCH_W),
  localparam int BSEL_W   = OFFSET_W - BANK_LSB,
  localparam int RATIO    = BANK_W / FETCH_W,
  localparam int WSEL_W   = min1_clog2(RATIO)
) (
  input  logic                clock,
  input  logic                reset,
`ifdef ICACHE_HIT_READ_FLUSH_EN
  input  logic                flush,
`endif
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [INDEX_W-1:0]  req_index,
  input  logic [WAY_W-1:0]    req_way,
  input  logic [OFFSET_W-1:0] req_offset,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [FETCH_W-1:0]  resp_rdata,
  output logic                da_valid,
  output logic [INDEX_W-1:0]  da_index,
  output logic [WAY_W-1:0]    da_way,
  output logic [BSEL_W-1:0]   da_bank,
  input  logic [BANK_W-1:0]   da_rdata,
  output logic                plru_valid,
  output logic [INDEX_W-1:0]  plru_index,
  output logic [WAY_W-1:0]    plru_way
);
  logic [1:0]         state_q, state_d;
  logic [WSEL_W-1:0]  wsel_q, wsel_d;
  logic [FETCH_W-1:0] hold_q, live_word;
  logic               accept, flush_w, hold_en;
`ifdef ICACHE_HIT_READ_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif
  assign req_ready  = !reset && !flush_w && (state_q == ST_EMPTY || resp_ready);
  assign accept     = req_valid && req_ready;
  assign resp_valid = !reset && state_q != ST_EMPTY;
  assign da_valid   = accept;
  assign plru_valid = accept;
  assign da_index   = req_index;
  assign plru_index = req_index;
  assign da_way     = req_way;
  assign plru_way   = req_way;
  assign da_bank    = req_offset[OFFSET_W-1:BANK_LSB];
  assign hold_en    = state_q == ST_LIVE && !resp_ready;
  assign resp_rdata = state_q == ST_HELD ? hold_q : live_word;
  if (RATIO > 1) begin : g_multi
    logic [RATIO-1:0][FETCH_W-1:0] words;
    logic unused_offset;
    assign words         = da_rdata;
    assign wsel_d        = req_offset[BANK_LSB-1:WORD_LSB];
    assign live_word     = words[wsel_q];
    assign unused_offset = ^req_offset[WORD_LSB-1:0];
  end else begin : g_single
    logic unused_offset;
    assign wsel_d        = '0;
    assign live_word     = da_rdata;
    assign unused_offset = ^{req_offset[BANK_LSB-1:0], wsel_q};
  end
  // next state: a consumed or empty slot refills on accept, an unconsumed one holds; flush empties
  always_comb
    state_d = flush_w ? ST_EMPTY
            : (state_q == ST_EMPTY || resp_ready) ? (accept ? ST_LIVE : ST_EMPTY)
            : ST_HELD;
  // state register
  always_ff @(posedge clock)
    if (reset) state_q <= ST_EMPTY;
    else state_q <= state_d;
  dff_en #(.W(WSEL_W)) u_wsel (
    .clk_i(clock), .rst_i(reset), .en_i(accept), .d_i(wsel_d), .q_o(wsel_q)
  );
  dff_en #(.W(FETCH_W)) u_hold (
    .clk_i(clock), .rst_i(reset), .en_i(hold_en), .d_i(live_word), .q_o(hold_q)
  );
endmodule

// File: tb/tb_icache_hit_read_pipe.sv
// tb_icache_hit_read_pipe: directed and random checks against a valid/data reference model
module tb_icache_hit_read_pipe;
  logic clk = 1'b0;
  logic reset, flush;
  logic req_valid, req_ready, resp_valid, resp_ready, da_valid, plru_valid;
  logic [5:0] req_index, req_offset, da_index, plru_index;
  logic [2:0] req_way, da_way, plru_way;
  logic [1:0] da_bank;
  logic [63:0] resp_rdata;
  logic [127:0] da_rdata;
  logic req_valid32, req_ready32, resp_valid32, resp_ready32, da_valid32, plru_valid32;
  logic [5:0] req_offset32, da_index32, plru_index32;
  logic [2:0] da_way32, plru_way32;
  logic [1:0] da_bank32;
  logic [31:0] resp_rdata32;
  logic [127:0] da_rdata32;
  int total = 0, passed = 0, fails = 0;
  bit m_pend = 0, m_held = 0;
  bit m_wsel = 0;
  logic [63:0] m_hword = '0;
  logic [127:0] r;
  always #5 clk = ~clk;
  icache_hit_read_pipe #(.INDEX_W(6), .WAY_N(8), .OFFSET_W(6), .BANK_W(128), .FETCH_W(64)) dut (
    .clock(clk), .reset(reset),
`ifdef ICACHE_HIT_READ_FLUSH_EN
    .flush(flush),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index), .req_way(req_way),
    .req_offset(req_offset), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .da_valid(da_valid), .da_index(da_index), .da_way(da_way),
    .da_bank(da_bank), .da_rdata(da_rdata), .plru_valid(plru_valid), .plru_index(plru_index),
    .plru_way(plru_way)
  );
  icache_hit_read_pipe #(.INDEX_W(6), .WAY_N(8), .OFFSET_W(6), .BANK_W(128), .FETCH_W(32)) dut32 (
    .clock(clk), .reset(reset),
`ifdef ICACHE_HIT_READ_FLUSH_EN
    .flush(1'b0),
`endif
    .req_valid(req_valid32), .req_ready(req_ready32), .req_index(req_index), .req_way(req_way),
    .req_offset(req_offset32), .resp_valid(resp_valid32), .resp_ready(resp_ready32),
    .resp_rdata(resp_rdata32), .da_valid(da_valid32), .da_index(da_index32), .da_way(da_way32),
    .da_bank(da_bank32), .da_rdata(da_rdata32), .plru_valid(plru_valid32),
    .plru_index(plru_index32), .plru_way(plru_way32)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one clock cycle: drive inputs, compare outputs with the model, then advance the model
  task automatic step(input bit rst, input bit fl, input bit rv, input logic [5:0] idx,
                      input logic [2:0] way, input logic [5:0] off, input bit rr,
                      input logic [127:0] rd);
    logic [127:0] sh;
    logic [63:0] w;
    bit f, ev, erdy, eacc;
`ifdef ICACHE_HIT_READ_FLUSH_EN
    f = fl;
`else
    f = 1'b0;
`endif
    @(negedge clk);
    reset = rst; flush = f; req_valid = rv; req_index = idx; req_way = way;
    req_offset = off; resp_ready = rr; da_rdata = rd;
    #1;
    sh = rd >> (m_wsel * 64);
    w = m_pend ? sh[63:0] : m_hword;
    ev = !rst && (m_pend || m_held);
    erdy = !rst && !f && (!ev || rr);
    eacc = rv && erdy;
    chk("resp_valid", resp_valid, ev);
    if (ev) chk("resp_rdata", resp_rdata, w);
    chk("req_ready", req_ready, erdy);
    chk("da_valid", da_valid, eacc);
    chk("plru_valid", plru_valid, eacc);
    if (eacc) begin
      chk("da_index", da_index, idx);
      chk("da_way", da_way, way);
      chk("da_bank", da_bank, off / 16);
      chk("plru_index", plru_index, idx);
      chk("plru_way", plru_way, way);
    end
    @(posedge clk);
    if (rst || f) begin
      m_pend = 0;
      m_held = 0;
    end else begin
      m_held = ev && !rr;
      if (m_held) m_hword = w;
      m_pend = eacc;
      m_wsel = (off / 8) % 2 == 1;
    end
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  initial begin
    reset = 1; flush = 0; req_valid = 0; req_index = 0; req_way = 0; req_offset = 0;
    resp_ready = 0; da_rdata = 0;
    req_valid32 = 0; req_offset32 = 0; resp_ready32 = 1; da_rdata32 = 0;
    step(1, 0, 1, 6'd1, 3'd1, 6'h00, 1, rnd128());
    step(1, 0, 0, 6'd0, 3'd0, 6'h00, 1, rnd128());
    step(0, 0, 1, 6'd5, 3'd2, 6'h08, 1, rnd128());
    step(0, 0, 0, 6'd0, 3'd0, 6'h00, 1, 128'h0123456789abcdef_fedcba9876543210);
    for (int i = 0; i < 4; i++)
      step(0, 0, 1, 6'(i * 9), 3'(i), 6'(i * 8), 1, rnd128());
    step(0, 0, 0, 6'd0, 3'd0, 6'h00, 1, rnd128());
    step(0, 0, 1, 6'd33, 3'd7, 6'h38, 1, rnd128());
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 6'd2, 3'd3, 6'h10, 0, rnd128());
    step(0, 0, 0, 6'd0, 3'd0, 6'h00, 1, rnd128());
    step(0, 0, 0, 6'd0, 3'd0, 6'h00, 1, rnd128());
    step(0, 0, 1, 6'd12, 3'd4, 6'h28, 1, rnd128());
    step(0, 0, 0, 6'd0, 3'd0, 6'h00, 0, rnd128());
    step(1, 0, 0, 6'd0, 3'd0, 6'h00, 0, rnd128());
    step(0, 0, 0, 6'd0, 3'd0, 6'h00, 1, rnd128());
    step(0, 0, 0, 6'd0, 3'd0, 6'h00, 1, rnd128());
`ifdef ICACHE_HIT_READ_FLUSH_EN
    step(0, 0, 1, 6'd7, 3'd1, 6'h18, 1, rnd128());
    step(0, 1, 1, 6'd8, 3'd2, 6'h20, 1, rnd128());
    step(0, 0, 0, 6'd0, 3'd0, 6'h00, 1, rnd128());
`endif
    @(negedge clk);
    req_valid32 = 1; req_offset32 = 6'h3c; resp_ready32 = 1;
    #1;
    chk("u32_da_valid", da_valid32, 1);
    chk("u32_da_bank", da_bank32, 3);
    @(posedge clk);
    @(negedge clk);
    req_valid32 = 0;
    r = rnd128();
    da_rdata32 = r;
    #1;
    chk("u32_resp_valid", resp_valid32, 1);
    chk("u32_resp_rdata", resp_rdata32, r[127:96]);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("u32_idle", resp_valid32, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(49) == 0, $urandom_range(19) == 0, $urandom_range(1) == 1,
           6'($urandom), 3'($urandom), 6'($urandom), $urandom_range(9) < 7, rnd128());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
